// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: fetch-side push port, decode-side head/pop port and status.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 16,
  parameter int IW    = 32,
  parameter int AW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              push_valid;
  logic [3:0]        push_cnt;
  logic [8*IW-1:0]   push_instr;
  logic [8*AW-1:0]   push_pc;
  logic              push_ready;
  logic [1:0]        pop_cnt;
  logic [3*IW-1:0]   head_instr;
  logic [3*AW-1:0]   head_pc;
  logic [2:0]        head_valid;
  logic [CW-1:0]     count;
  logic              underflow;

  modport master (
    output flush, push_valid, push_cnt, push_instr, push_pc, pop_cnt,
    input  push_ready, head_instr, head_pc, head_valid, count, underflow
  );

  modport slave (
    input  flush, push_valid, push_cnt, push_instr, push_pc, pop_cnt,
    output push_ready, head_instr, head_pc, head_valid, count, underflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: absorbs up to 8 instr/PC pairs per cycle, presents the oldest 3.
// Define FQ_BYPASS_EN to forward a bundle pushed into an empty queue to head_* in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 16,
  parameter int IW    = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem_instr [DEPTH];
  logic [AW-1:0] mem_pc    [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt_q;
  logic          uf_q;

  logic [CW-1:0] free, push_w, pop_w, avail, eff_pop;
  logic          push_acc, bypass, over;

  assign free     = CW'(DEPTH) - cnt_q;
  assign push_w   = CW'(fq.push_cnt);
  assign pop_w    = CW'(fq.pop_cnt);
  assign push_acc = fq.push_valid && !fq.flush && (fq.push_cnt <= 4'd8) && (push_w <= free);

`ifdef FQ_BYPASS_EN
  assign bypass = push_acc && (cnt_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // In bypass the freshly pushed slots are the only entries decode can consume.
  assign avail   = bypass ? push_w : cnt_q;
  assign over    = pop_w > avail;
  assign eff_pop = over ? avail : pop_w;

  assign fq.push_ready = free >= CW'(8);
  assign fq.count      = cnt_q;
  assign fq.underflow  = uf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      uf_q   <= 1'b0;
    end else if (fq.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(push_w);
      rd_ptr <= rd_ptr + PW'(eff_pop);
      cnt_q  <= cnt_q + (push_acc ? push_w : '0) - eff_pop;
      if (over) uf_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; head_valid masks stale contents, and
  // leaving it out of reset lets the array map onto plain RAM/flops without reset muxes.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < fq.push_cnt) begin
          mem_instr[wr_ptr + PW'(k)] <= fq.push_instr[k*IW +: IW];
          mem_pc[wr_ptr + PW'(k)]    <= fq.push_pc[k*AW +: AW];
        end
      end
    end
  end

  always_comb begin
    fq.head_valid = '0;
    fq.head_instr = '0;
    fq.head_pc    = '0;
    for (int s = 0; s < 3; s++) begin
`ifdef FQ_BYPASS_EN
      if (bypass) begin
        if (4'(s) < fq.push_cnt) begin
          fq.head_valid[s]           = 1'b1;
          fq.head_instr[s*IW +: IW]  = fq.push_instr[s*IW +: IW];
          fq.head_pc[s*AW +: AW]     = fq.push_pc[s*AW +: AW];
        end
      end else
`endif
      if (cnt_q > CW'(s)) begin
        fq.head_valid[s]           = 1'b1;
        fq.head_instr[s*IW +: IW]  = mem_instr[rd_ptr + PW'(s)];
        fq.head_pc[s*AW +: AW]     = mem_pc[rd_ptr + PW'(s)];
      end
    end
  end
endmodule
